// File: rtl/persp_div_pkg.sv
// Shared types and constants for the perspective-divide sequencer.
package persp_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    typedef logic [1:0] comp_idx_t;

    // Saturated quotients are symmetric, so -max is used rather than the most negative code.
    localparam int                  PD_WIDTH = 16;
    localparam logic [PD_WIDTH-1:0] SAT_POS  = {1'b0, {(PD_WIDTH-1){1'b1}}};
    localparam logic [PD_WIDTH-1:0] SAT_NEG  = {1'b1, {(PD_WIDTH-2){1'b0}}, 1'b1};

endpackage

// File: rtl/persp_div_seq_sgn_mag.sv
// sgn_mag: conditional two's-complement negation. It takes a magnitude when
// neg is the value's own sign bit, and re-applies a sign to an unsigned quotient.
module sgn_mag #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/persp_div_seq.sv
// persp_div_seq: runs x/w, y/w, z/w through a shared unsigned divider.
// Define PERSP_DIV_CLAMP_EN to saturate out-of-range quotients instead of wrapping.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a vertex; w==0 short-cuts straight to OUT
// ISSUE | start the divider on component k once it is not busy
// WAIT  | wait for div_done, store the signed quotient, advance k
// OUT   | hold the result until the rasteriser takes it
module persp_div_seq
    import persp_div_pkg::*;
#(
    parameter int WIDTH = PD_WIDTH,
    parameter int FBITS = 8,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [WIDTH-1:0] in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic             div_dbz,
    input  logic [WIDTH-1:0] div_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             out_ovf
);

    state_t           state, state_n;
    comp_idx_t        k;
    logic [WIDTH-1:0] x_r, y_r, z_r, w_r;
    logic [WIDTH-1:0] res_x, res_y, res_z;
    logic [TAG_W-1:0] tag_r;
    logic             dbz_r, ovf_r;
    logic [WIDTH-1:0] comp, mag_a, mag_b, q_signed, res_d;
    logic             res_neg, res_we, last_k, clamp_hit;

    always_comb begin
        comp = x_r;
        case (k)
            2'd1:    comp = y_r;
            2'd2:    comp = z_r;
            default: comp = x_r;
        endcase
    end

    assign res_neg = comp[WIDTH-1] ^ w_r[WIDTH-1];
    assign last_k  = (k == 2'd2);

    sgn_mag #(.WIDTH(WIDTH)) u_mag_a (.val(comp),    .neg(comp[WIDTH-1]), .res(mag_a));
    sgn_mag #(.WIDTH(WIDTH)) u_mag_b (.val(w_r),     .neg(w_r[WIDTH-1]),  .res(mag_b));
    sgn_mag #(.WIDTH(WIDTH)) u_res   (.val(div_val), .neg(res_neg),       .res(q_signed));

`ifdef PERSP_DIV_CLAMP_EN
    // |c| >= |w| * 2^(WIDTH-1-FBITS) means the quotient cannot fit in WIDTH signed bits.
    logic [2*WIDTH-1:0] clamp_lim;
    assign clamp_lim = {{WIDTH{1'b0}}, mag_b} << (WIDTH - 1 - FBITS);
    assign clamp_hit = (state == S_ISSUE) && ({{WIDTH{1'b0}}, mag_a} >= clamp_lim);
`else
    assign clamp_hit = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        res_we    = 1'b0;
        res_d     = q_signed;
        case (state)
            S_IDLE: begin
                if (in_valid) state_n = (in_w == '0) ? S_OUT : S_ISSUE;
            end
            S_ISSUE: begin
                if (clamp_hit) begin
                    res_we  = 1'b1;
                    res_d   = res_neg ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
                    state_n = last_k ? S_OUT : S_ISSUE;
                end else if (!div_busy) begin
                    div_start = 1'b1;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_done) begin
                    res_we  = 1'b1;
                    res_d   = div_dbz ? '0 : q_signed;
                    state_n = last_k ? S_OUT : S_ISSUE;
                end
            end
            S_OUT: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            w_r   <= '0;
            res_x <= '0;
            res_y <= '0;
            res_z <= '0;
            tag_r <= '0;
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && in_valid) begin
                x_r   <= in_x;
                y_r   <= in_y;
                z_r   <= in_z;
                w_r   <= in_w;
                tag_r <= in_tag;
                k     <= '0;
                dbz_r <= (in_w == '0);
                ovf_r <= 1'b0;
                res_x <= '0;
                res_y <= '0;
                res_z <= '0;
            end
            if (res_we) begin
                case (k)
                    2'd1:    res_y <= res_d;
                    2'd2:    res_z <= res_d;
                    default: res_x <= res_d;
                endcase
                if (!last_k) k <= k + 2'd1;
                if (state == S_ISSUE) ovf_r <= 1'b1;
                if (state == S_WAIT && div_dbz) dbz_r <= 1'b1;
            end
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign div_a     = mag_a;
    assign div_b     = mag_b;
    assign out_x     = res_x;
    assign out_y     = res_y;
    assign out_z     = res_z;
    assign out_tag   = tag_r;
    assign out_dbz   = dbz_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_persp_div_seq.sv
// Testbench for persp_div_seq: behavioural divider plus an arithmetic reference
// model of the perspective divide, with directed and random vertices.
module tb_persp_div_seq;
    localparam int     W   = 16;
    localparam int     F   = 8;
    localparam int     TW  = 8;
    localparam int     D   = 25;
    localparam longint MOD = longint'(1) << W;
    localparam longint MAXP = (MOD / 2) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_x, in_y, in_z, in_w;
    logic [TW-1:0] in_tag;
    logic          div_start;
    logic [W-1:0]  div_a, div_b;
    logic          div_busy, div_done, div_dbz;
    logic [W-1:0]  div_val;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_x, out_y, out_z;
    logic [TW-1:0] out_tag;
    logic          out_dbz, out_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    persp_div_seq #(.WIDTH(W), .FBITS(F), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w), .in_tag(in_tag),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz), .div_val(div_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_tag(out_tag),
        .out_dbz(out_dbz), .out_ovf(out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural unsigned fixed-point divider: done arrives D cycles after the start cycle.
    logic          m_busy, m_done, m_dbz;
    logic [W-1:0]  m_val, m_a, m_b;
    int            m_cnt;
    logic          busy_force = 1'b0;
    logic          inj_done   = 1'b0;
    logic          dbz_en     = 1'b0;
    logic [W-1:0]  dbz_match  = '0;

    assign div_busy = m_busy | busy_force;
    assign div_done = m_done | inj_done;
    assign div_dbz  = m_dbz;
    assign div_val  = m_val;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_val  <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (div_start) begin
                m_a    <= div_a;
                m_b    <= div_b;
                m_cnt  <= D - 1;
                m_busy <= 1'b1;
            end else if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
                m_cnt  <= 0;
                if (m_b == '0 || (dbz_en && m_a == dbz_match)) begin
                    m_dbz <= 1'b1;
                    m_val <= '1;
                end else begin
                    m_val <= W'((longint'(m_a) << F) / longint'(m_b));
                end
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Every divider start must carry the next expected dividend and the vertex's |w|.
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] cur_b;
    int           n_starts = 0;

    always @(negedge clk) begin
        if (!rst && div_start) begin
            n_starts++;
            if (exp_a_q.size() > 0) chk("div_a", div_a, exp_a_q.pop_front());
            else                    chk("unexpected_start", 1, 0);
            chk("div_b", div_b, cur_b);
        end
    end

    function automatic longint mag(input logic [W-1:0] v);
        return v[W-1] ? MOD - longint'(v) : longint'(v);
    endfunction

    function automatic void ref_comp(input logic [W-1:0] c, input logic [W-1:0] w,
                                     output logic [W-1:0] r, output bit ovf, output bit divided);
        longint ac, aw, q;
        bit     neg;
        ac  = mag(c);
        aw  = mag(w);
        neg = c[W-1] ^ w[W-1];
        ovf = 1'b0;
        divided = 1'b1;
`ifdef PERSP_DIV_CLAMP_EN
        if (ac >= aw * (longint'(1) << (W - 1 - F))) begin
            r = neg ? W'(MOD - MAXP) : W'(MAXP);
            ovf = 1'b1;
            divided = 1'b0;
            return;
        end
`endif
        q = ((ac << F) / aw) % MOD;
        r = neg ? W'((MOD - q) % MOD) : W'(q);
    endfunction

    task automatic run_vertex(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] z, input logic [W-1:0] w,
                              input logic [TW-1:0] tag, input bit chk_lat, input bit hold_out);
        logic [W-1:0] c[3];
        logic [W-1:0] r[3];
        bit ov, dv, e_ovf, e_dbz;
        int e_lat, lat, s0, e_starts;
        c[0] = x; c[1] = y; c[2] = z;
        e_ovf = 1'b0; e_dbz = (w == '0); e_lat = 1; e_starts = 0;
        cur_b = W'(mag(w));
        for (int i = 0; i < 3; i++) begin
            if (w == '0) begin
                r[i] = '0;
            end else begin
                ref_comp(c[i], w, r[i], ov, dv);
                e_ovf |= ov;
                if (dv) begin
                    exp_a_q.push_back(W'(mag(c[i])));
                    e_starts++;
                    e_lat += 1 + D;
                    if (dbz_en && mag(c[i]) == longint'(dbz_match)) begin
                        r[i]  = '0;
                        e_dbz = 1'b1;
                    end
                end else begin
                    e_lat += 1;
                end
            end
        end
        out_ready = !hold_out;
        s0 = n_starts;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_x = x; in_y = y; in_z = z; in_w = w; in_tag = tag; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_x = W'($urandom); in_y = W'($urandom); in_z = W'($urandom);
        in_w = W'($urandom); in_tag = TW'($urandom);
        lat = 1;
        while (!out_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", out_valid, 1);
        if (chk_lat) chk("latency", lat, e_lat);
        chk("out_x", out_x, r[0]);
        chk("out_y", out_y, r[1]);
        chk("out_z", out_z, r[2]);
        chk("out_tag", out_tag, tag);
        chk("out_dbz", out_dbz, e_dbz);
        chk("out_ovf", out_ovf, e_ovf);
        chk("n_starts", n_starts - s0, e_starts);
        if (hold_out) begin
            for (int i = 0; i < 10; i++) begin
                inj_done = (i == 4);
                @(negedge clk);
                chk("bp_valid", out_valid, 1);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_x", out_x, r[0]);
                chk("bp_y", out_y, r[1]);
                chk("bp_z", out_z, r[2]);
                chk("bp_tag", out_tag, tag);
            end
            inj_done  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("out_released", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        logic [W-1:0] rx, ry, rz, rw;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0; in_w = '0; in_tag = '0; cur_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_dbz", out_dbz, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;

        // A done pulse while idle must be ignored.
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;

        run_vertex(16'h0200, 16'hFF00, 16'h0080, 16'h0200, 8'h5A, 1, 0);
        run_vertex(16'h0300, 16'hFD00, 16'h0000, 16'hFF00, 8'h11, 1, 0);
        run_vertex(16'h1234, 16'h8000, 16'h7FFF, 16'h0000, 8'h22, 1, 0);
        run_vertex(16'h6400, 16'h0100, 16'h0000, 16'h0040, 8'h33, 1, 0);
        run_vertex(16'h8000, 16'h7FFF, 16'hC000, 16'h0100, 8'h34, 1, 0);
        run_vertex(16'h0100, 16'h0200, 16'h0300, 16'h0100, 8'h44, 1, 1);

        dbz_en = 1'b1; dbz_match = 16'h0200;
        run_vertex(16'h0100, 16'hFE00, 16'h0300, 16'h0100, 8'h55, 1, 0);
        dbz_en = 1'b0;

        // Divider busy for 5 cycles on entry to the first issue.
        busy_force = 1'b1;
        fork
            run_vertex(16'h0280, 16'hFE00, 16'h0040, 16'h0100, 8'h66, 0, 0);
            begin
                @(posedge clk);
                while (!in_valid) @(posedge clk);
                s1 = n_starts;
                repeat (5) begin
                    @(negedge clk);
                    chk("busy_hold_start", div_start, 0);
                end
                @(posedge clk);
                #1 busy_force = 1'b0;
                @(negedge clk);
                chk("busy_release_start", div_start, 1);
                @(negedge clk);
                chk("busy_single_pulse", div_start, 0);
                chk("busy_start_count", n_starts - s1, 1);
            end
        join

        // Reset while waiting on the y component.
        cur_b = 16'h0100;
        exp_a_q.push_back(16'h0100);
        exp_a_q.push_back(16'h0200);
        exp_a_q.push_back(16'h0300);
        s0 = n_starts;
        @(negedge clk);
        in_x = 16'h0100; in_y = 16'h0200; in_z = 16'h0300; in_w = 16'h0100; in_tag = 8'h77;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (34) @(negedge clk);
        chk("pre_rst_starts", n_starts - s0, 2);
        chk("pre_rst_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_div_start", div_start, 0);
        chk("mid_rst_out_y", out_y, 0);
        rst = 1'b0;
        exp_a_q.delete();
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        run_vertex(16'hFF80, 16'h0180, 16'h0400, 16'h0080, 8'h78, 1, 0);

        for (int n = 0; n < 40; n++) begin
            rx = W'($urandom); ry = W'($urandom); rz = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rw = '0;
                1, 2, 3: rw = W'($urandom_range(1, 16'h0100));
                default: rw = W'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) rw = -rw;
            if ($urandom_range(0, 3) == 0) rx = W'($urandom_range(0, 16'h00FF));
            run_vertex(rx, ry, rz, rw, TW'($urandom), 1, ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
